// File: rtl/skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : skew_feeder
// Purpose  : Accepts one ROWS-wide operand vector per beat and re-emits it
//            diagonally skewed (lane r delayed r extra cycles) for a systolic
//            PE array; runs one tile per start, drains, then pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module skew_feeder #(
  parameter int ROWS  = 4,
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      tile_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*WIDTH-1:0] in_data,
  output logic [ROWS*WIDTH-1:0] out_data,
  output logic [ROWS-1:0]       out_valid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;

  logic [ROWS*WIDTH-1:0]   inj_data_q;
  logic                    inj_valid_q;
  logic                    inj_last_q;
  logic                    last_q [0:ROWS-1];

  logic                    w_accept;
  logic                    w_last_beat;
  logic                    w_done;

  assign w_accept    = in_valid & in_ready;
  assign w_last_beat = (cnt_q == (len_q - c_len_one));

  // ------------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && (tile_len != '0)) begin
          state_d = ST_STREAM;
          len_d   = tile_len;
          cnt_d   = '0;
        end
      end
      ST_STREAM: begin
        if (w_accept) begin
          if (w_last_beat) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + c_len_one;
          end
        end
      end
      ST_DRAIN: begin
        if (w_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready = (state_q == ST_STREAM);
  assign busy     = (state_q != ST_IDLE);

  // ------------------------------------------------------------------------
  // Shared injection register: a cycle without an accepted beat becomes a
  // zero bubble, so every lane chain advances in lock-step.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      inj_data_q  <= '0;
      inj_valid_q <= 1'b0;
      inj_last_q  <= 1'b0;
    end else begin
      inj_data_q  <= w_accept ? in_data : '0;
      inj_valid_q <= w_accept;
      inj_last_q  <= w_accept & w_last_beat;
    end
  end

  // Tag of the tile's final element, tracking the deepest lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < ROWS; k++) begin
        last_q[k] <= 1'b0;
      end
    end else begin
      last_q[0] <= inj_last_q;
      for (int k = 1; k < ROWS; k++) begin
        last_q[k] <= last_q[k-1];
      end
    end
  end

  assign w_done = (state_q == ST_DRAIN) && last_q[ROWS-1] && out_valid[ROWS-1];
  assign done   = w_done;

  // ------------------------------------------------------------------------
  // Per-lane delay chains; stage r of lane r is the output register.
  // ------------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [WIDTH-1:0] data_q  [0:r];
    logic             valid_q [0:r];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= r; k++) begin
          data_q[k]  <= '0;
          valid_q[k] <= 1'b0;
        end
      end else begin
        data_q[0]  <= inj_data_q[r*WIDTH +: WIDTH];
        valid_q[0] <= inj_valid_q;
        for (int k = 1; k <= r; k++) begin
          data_q[k]  <= data_q[k-1];
          valid_q[k] <= valid_q[k-1];
        end
      end
    end

    assign out_valid[r]                = valid_q[r];
    assign out_data[r*WIDTH +: WIDTH]  = valid_q[r] ? data_q[r] : '0;
  end

endmodule
`default_nettype wire
